// File: rtl/split_target_pkg.sv
// Shared types for the split-transaction target.
//   state_t       : controller state (IDLE, WAIT_WRITE_DATA, SENDING)
//   queue_entry_t : one deferred read, {addr, counter}
package split_target_pkg;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    WAIT_WRITE_DATA = 2'd1,
    SENDING         = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  counter;
  } queue_entry_t;

endpackage

// File: rtl/split_target_mo_if.sv
// Bus between a requester/arbiter and the split target.
//   master : drives the request (address, write data, rw) and split_grant
//   slave  : the target; drives split_req, read data, acks and target_ready
interface split_target_mo_if #(
  parameter int DATA_W = 8
) ();
  logic              split_grant;
  logic [15:0]       target_addr_in;
  logic              target_addr_in_valid;
  logic [DATA_W-1:0] target_data_in;
  logic              target_data_in_valid;
  logic              target_rw;
  logic              split_req;
  logic [DATA_W-1:0] target_data_out;
  logic              target_data_out_valid;
  logic              target_ack;
  logic              target_split_ack;
  logic              target_ready;

  modport master (
    output split_grant, target_addr_in, target_addr_in_valid,
           target_data_in, target_data_in_valid, target_rw,
    input  split_req, target_data_out, target_data_out_valid,
           target_ack, target_split_ack, target_ready
  );

  modport slave (
    input  split_grant, target_addr_in, target_addr_in_valid,
           target_data_in, target_data_in_valid, target_rw,
    output split_req, target_data_out, target_data_out_valid,
           target_ack, target_split_ack, target_ready
  );
endinterface

// File: rtl/split_read_queue.sv
// In-order queue of deferred reads. Every entry carries its own latency
// counter that counts down each cycle (saturating at 0); the head is ready
// for return once its counter has reached 0.
//   push/push_addr : enqueue a read with counter = CNT_INIT
//   pop            : drop the head entry
//   head_ready     : queue not empty and head counter is 0
//   head_addr      : address of the head entry
//   full / empty   : occupancy flags (DEPTH entries = full)
module split_read_queue
  import split_target_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int CNT_INIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic              head_ready,
  output logic [ADDR_W-1:0] head_addr,
  output logic              full,
  output logic              empty
);

  // Storage is sized for the largest legal depth so the 3-bit pointers
  // index it exactly; only DEPTH slots are ever used.
  queue_entry_t r_q [8];
  logic [2:0]   r_head;
  logic [2:0]   r_tail;
  logic [3:0]   r_count;

  function automatic logic [2:0] nxt_ptr(input logic [2:0] p);
    return (p == 3'(DEPTH - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_q[i].counter != '0) r_q[i].counter <= r_q[i].counter - 1'b1;
      end
      // A fresh entry overrides the decrement of its slot.
      if (push) begin
        r_q[r_tail] <= '{addr: push_addr, counter: CNT_W'(CNT_INIT)};
        r_tail      <= nxt_ptr(r_tail);
      end
      if (pop) r_head <= nxt_ptr(r_head);
      if (push && !pop)      r_count <= r_count + 4'd1;
      else if (pop && !push) r_count <= r_count - 4'd1;
    end
  end

  assign empty      = (r_count == 4'd0);
  assign full       = (r_count == 4'(DEPTH));
  assign head_addr  = r_q[r_head].addr;
  assign head_ready = !empty && (r_q[r_head].counter == '0);

endmodule

// File: rtl/split_target_mo.sv
// Split-transaction memory target. Writes complete directly (or after a
// late data phase); reads are deferred through an in-order queue, then
// returned once the arbiter grants the split response.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : slave side of split_target_mo_if
//
// state           | meaning
// IDLE            | accepting requests, may take a split grant
// WAIT_WRITE_DATA | write address latched, waiting for write data
// SENDING         | head read popped, data returned on next edge
module split_target_mo
  import split_target_pkg::*;
#(
  parameter int DATA_W             = 8,
  parameter int INTERNAL_ADDR_BITS = 4,
  parameter int READ_LATENCY       = 4,
  parameter int MAX_OUTSTANDING    = 2
) (
  input logic              clk,
  input logic              rst_n,
  split_target_mo_if.slave bus
);

  localparam int IDX_W    = INTERNAL_ADDR_BITS;
  localparam int MEM_D    = 2 ** INTERNAL_ADDR_BITS;
  localparam int CNT_INIT = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

  state_t            r_state, w_state_nxt;
  logic              r_split_req, w_split_req_nxt;
  logic              r_ack, w_ack_nxt;
  logic              r_split_ack, w_split_ack_nxt;
  logic              r_valid, w_valid_nxt;
  logic [DATA_W-1:0] r_dout, w_dout_nxt;
  logic [IDX_W-1:0]  r_waddr, w_waddr_nxt;
  logic [IDX_W-1:0]  r_send_addr, w_send_addr_nxt;
  logic [DATA_W-1:0] r_mem [MEM_D];

  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [IDX_W-1:0]  w_req_idx;
  logic              w_push, w_pop;
  logic              w_head_ready, w_full, w_empty;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_ready, w_accept;

  split_read_queue #(
    .DEPTH    (MAX_OUTSTANDING),
    .CNT_INIT (CNT_INIT)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .push_addr  (bus.target_addr_in),
    .pop        (w_pop),
    .head_ready (w_head_ready),
    .head_addr  (w_head_addr),
    .full       (w_full),
    .empty      (w_empty)
  );

  // Only the low address bits select a memory word.
  assign w_req_idx = IDX_W'(bus.target_addr_in);
  // A grant cycle is reserved for popping, so no request competes with it.
  assign w_ready   = !w_full && (r_state == IDLE) && !bus.split_grant;
  assign w_accept  = bus.target_addr_in_valid && w_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_split_req_nxt = r_split_req;
    w_ack_nxt       = 1'b0;
    w_split_ack_nxt = 1'b0;
    w_valid_nxt     = 1'b0;
    w_dout_nxt      = r_dout;
    w_waddr_nxt     = r_waddr;
    w_send_addr_nxt = r_send_addr;
    w_mem_we        = 1'b0;
    w_mem_waddr     = w_req_idx;
    w_mem_wdata     = bus.target_data_in;
    w_push          = 1'b0;
    w_pop           = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_split_req && bus.split_grant) begin
          w_split_req_nxt = 1'b0;
          w_pop           = 1'b1;
          w_send_addr_nxt = IDX_W'(w_head_addr);
          w_state_nxt     = SENDING;
        end else if (w_accept) begin
          if (bus.target_rw) begin
            if (bus.target_data_in_valid) begin
              w_mem_we  = 1'b1;
              w_ack_nxt = 1'b1;
            end else begin
              w_waddr_nxt = w_req_idx;
              w_state_nxt = WAIT_WRITE_DATA;
            end
          end else if (READ_LATENCY == 0) begin
            w_dout_nxt  = r_mem[w_req_idx];
            w_valid_nxt = 1'b1;
            w_ack_nxt   = 1'b1;
          end else begin
            w_push          = 1'b1;
            w_split_ack_nxt = 1'b1;
          end
        end
      end
      WAIT_WRITE_DATA: begin
        if (bus.target_data_in_valid) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = r_waddr;
          w_ack_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      SENDING: begin
        // Memory is sampled now, so writes that landed after the read was
        // queued are reflected in the returned data.
        w_dout_nxt  = r_mem[r_send_addr];
        w_valid_nxt = 1'b1;
        w_ack_nxt   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (!r_split_req && w_head_ready && !w_empty) w_split_req_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_split_req <= 1'b0;
      r_ack       <= 1'b0;
      r_split_ack <= 1'b0;
      r_valid     <= 1'b0;
      r_dout      <= '0;
      r_waddr     <= '0;
      r_send_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_split_req <= w_split_req_nxt;
      r_ack       <= w_ack_nxt;
      r_split_ack <= w_split_ack_nxt;
      r_valid     <= w_valid_nxt;
      r_dout      <= w_dout_nxt;
      r_waddr     <= w_waddr_nxt;
      r_send_addr <= w_send_addr_nxt;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  assign bus.split_req             = r_split_req;
  assign bus.target_data_out       = r_dout;
  assign bus.target_data_out_valid = r_valid;
  assign bus.target_ack            = r_ack;
  assign bus.target_split_ack      = r_split_ack;
  assign bus.target_ready          = w_ready;

endmodule

// File: tb/tb_split_target_mo.sv
// Directed bench for split_target_mo: a READ_LATENCY=4 / MAX_OUTSTANDING=2
// instance for the split path and a READ_LATENCY=0 instance for direct reads.
module tb_split_target_mo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  split_target_mo_if #(.DATA_W(8)) bus  ();
  split_target_mo_if #(.DATA_W(8)) bus0 ();

  split_target_mo #(
    .DATA_W(8), .INTERNAL_ADDR_BITS(4), .READ_LATENCY(4), .MAX_OUTSTANDING(2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  split_target_mo #(
    .DATA_W(8), .INTERNAL_ADDR_BITS(4), .READ_LATENCY(0), .MAX_OUTSTANDING(2)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.split_grant          = 1'b0;
    bus.target_addr_in       = '0;
    bus.target_addr_in_valid = 1'b0;
    bus.target_data_in       = '0;
    bus.target_data_in_valid = 1'b0;
    bus.target_rw            = 1'b0;
  endtask

  task automatic idle_in0();
    bus0.split_grant          = 1'b0;
    bus0.target_addr_in       = '0;
    bus0.target_addr_in_valid = 1'b0;
    bus0.target_data_in       = '0;
    bus0.target_data_in_valid = 1'b0;
    bus0.target_rw            = 1'b0;
  endtask

  task automatic drive_req(input logic rw, input logic [15:0] a, input logic [7:0] d,
                           input logic dv);
    bus.target_rw            = rw;
    bus.target_addr_in       = a;
    bus.target_addr_in_valid = 1'b1;
    bus.target_data_in       = d;
    bus.target_data_in_valid = dv;
  endtask

  // Wait (bounded) for split_req, grant it, and check the returned data.
  task automatic service(input logic [7:0] exp, input string tag);
    int n = 0;
    while (!bus.split_req && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_req_seen"}, 32'(bus.split_req), 32'd1);
    bus.split_grant = 1'b1;
    step();
    bus.split_grant = 1'b0;
    chk({tag, "_req_drop"}, 32'(bus.split_req), 32'd0);
    chk({tag, "_ready_sending"}, 32'(bus.target_ready), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(bus.target_data_out_valid), 32'd1);
    chk({tag, "_ack"}, 32'(bus.target_ack), 32'd1);
    chk({tag, "_data"}, 32'(bus.target_data_out), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    idle_in();
    idle_in0();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_split_req", 32'(bus.split_req), 32'd0);
    chk("rst_ack", 32'(bus.target_ack), 32'd0);
    chk("rst_split_ack", 32'(bus.target_split_ack), 32'd0);
    chk("rst_valid", 32'(bus.target_data_out_valid), 32'd0);
    chk("rst_dout", 32'(bus.target_data_out), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("ready_idle", 32'(bus.target_ready), 32'd1);

    // Write 0x5A to 0x0003 with data.
    drive_req(1'b1, 16'h0003, 8'h5A, 1'b1);
    step();
    idle_in();
    chk("wr_ack", 32'(bus.target_ack), 32'd1);
    chk("wr_no_split_ack", 32'(bus.target_split_ack), 32'd0);
    step();
    chk("wr_ack_pulse", 32'(bus.target_ack), 32'd0);

    // Read 0x0003, latency 4: split_ack after the accept edge, split_req on
    // the fourth edge after it (fifth counting the accept edge).
    drive_req(1'b0, 16'h0003, 8'h00, 1'b0);
    step();                                      // accept edge
    idle_in();
    chk("rd_split_ack", 32'(bus.target_split_ack), 32'd1);
    chk("rd_no_ack", 32'(bus.target_ack), 32'd0);
    step();
    chk("split_ack_pulse", 32'(bus.target_split_ack), 32'd0);
    bus.split_grant = 1'b1;                      // stray grant, split_req low
    #1;
    chk("ready_low_grant", 32'(bus.target_ready), 32'd0);
    step();
    bus.split_grant = 1'b0;
    chk("stray_grant_req", 32'(bus.split_req), 32'd0);
    chk("stray_grant_valid", 32'(bus.target_data_out_valid), 32'd0);
    step();
    chk("split_req_early", 32'(bus.split_req), 32'd0);
    step();
    chk("split_req_rise", 32'(bus.split_req), 32'd1);
    bus.split_grant = 1'b1;
    step();
    bus.split_grant = 1'b0;
    chk("grant_req_drop", 32'(bus.split_req), 32'd0);
    chk("grant_no_valid", 32'(bus.target_data_out_valid), 32'd0);
    step();
    chk("rd_valid", 32'(bus.target_data_out_valid), 32'd1);
    chk("rd_ack", 32'(bus.target_ack), 32'd1);
    chk("rd_data", 32'(bus.target_data_out), 32'h5A);
    step();
    chk("rd_valid_pulse", 32'(bus.target_data_out_valid), 32'd0);
    chk("rd_ack_pulse", 32'(bus.target_ack), 32'd0);
    chk("data_hold", 32'(bus.target_data_out), 32'h5A);

    // Write address without data; data three cycles later.
    drive_req(1'b1, 16'h0005, 8'h00, 1'b0);
    step();
    idle_in();
    chk("late_wr_no_ack", 32'(bus.target_ack), 32'd0);
    chk("ready_wait", 32'(bus.target_ready), 32'd0);
    step();
    step();
    chk("ready_wait2", 32'(bus.target_ready), 32'd0);
    bus.target_data_in       = 8'h77;
    bus.target_data_in_valid = 1'b1;
    step();
    idle_in();
    chk("late_wr_ack", 32'(bus.target_ack), 32'd1);
    step();
    chk("late_wr_ack_pulse", 32'(bus.target_ack), 32'd0);
    chk("ready_after_wr", 32'(bus.target_ready), 32'd1);

    // Read 0x0001 queued, then write 0xC3 to it: the read returns 0xC3.
    drive_req(1'b0, 16'h0001, 8'h00, 1'b0);
    step();
    drive_req(1'b1, 16'h0001, 8'hC3, 1'b1);
    step();
    idle_in();
    chk("raw_wr_ack", 32'(bus.target_ack), 32'd1);
    service(8'hC3, "raw_rd");
    step();

    // Three back-to-back reads with two slots: third waits for first pop.
    drive_req(1'b0, 16'h0003, 8'h00, 1'b0);
    step();
    drive_req(1'b0, 16'h0005, 8'h00, 1'b0);
    step();
    drive_req(1'b0, 16'h0001, 8'h00, 1'b0);
    #1;
    chk("ready_full", 32'(bus.target_ready), 32'd0);
    service(8'h5A, "q1");
    chk("slot_freed", 32'(bus.target_ready), 32'd1);
    step();
    idle_in();
    chk("third_split_ack", 32'(bus.target_split_ack), 32'd1);
    service(8'h77, "q2");
    service(8'hC3, "q3");
    step();

    // Reset with two reads queued: nothing comes out afterwards.
    drive_req(1'b0, 16'h0003, 8'h00, 1'b0);
    step();
    drive_req(1'b0, 16'h0005, 8'h00, 1'b0);
    step();
    idle_in();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_split_ack", 32'(bus.target_split_ack), 32'd0);
    chk("mid_rst_dout", 32'(bus.target_data_out), 32'd0);
    chk("mid_rst_req", 32'(bus.split_req), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.split_req || bus.target_ack || bus.target_split_ack ||
          bus.target_data_out_valid) pulses++;
    end
    chk("post_rst_quiet", 32'(pulses), 32'd0);
    chk("post_rst_ready", 32'(bus.target_ready), 32'd1);

    // Non-split instance: read data returns one cycle after acceptance.
    bus0.target_rw            = 1'b1;
    bus0.target_addr_in       = 16'h0002;
    bus0.target_addr_in_valid = 1'b1;
    bus0.target_data_in       = 8'h3C;
    bus0.target_data_in_valid = 1'b1;
    step();
    idle_in0();
    chk("rl0_wr_ack", 32'(bus0.target_ack), 32'd1);
    step();
    bus0.target_rw            = 1'b0;
    bus0.target_addr_in       = 16'h0002;
    bus0.target_addr_in_valid = 1'b1;
    step();
    idle_in0();
    chk("rl0_rd_valid", 32'(bus0.target_data_out_valid), 32'd1);
    chk("rl0_rd_ack", 32'(bus0.target_ack), 32'd1);
    chk("rl0_rd_data", 32'(bus0.target_data_out), 32'h3C);
    chk("rl0_no_split_ack", 32'(bus0.target_split_ack), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus0.split_req || bus0.target_split_ack) pulses++;
    end
    chk("rl0_no_split", 32'(pulses), 32'd0);
    chk("rl0_data_hold", 32'(bus0.target_data_out), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
